regfile_port_sched: RTL and testbench
=====================================

# regfile_port_sched

Sequencing and arbitration controller placed in front of the 64 x 32 register file (`regfile_32bit`). That register file has one write port and, on any edge, either writes or reads. This block shares that single access slot between one read requester (decode) and two write requesters: A is ALU writeback and B is load return. It also zero-initializes every writable register after reset.

## Interface
- RWIDTH, 6: register address width (2**RWIDTH registers).
- DWIDTH, 32: data width.
- STARVE_LIMIT, 4: consecutive denied cycles after which a pending read gets top priority (range 1..15).

Ports:
- clk  in  1  single clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- rd_req_valid  in  1  read request pending.
- rd_req_ready  out  1  read request accepted this cycle.
- rd_ra1, rd_ra2  in  RWIDTH  read addresses.
- rd_rsp_valid  out  1  read data valid (one-cycle pulse).
- rd_rsp_d1, rd_rsp_d2  out  DWIDTH  read data.
- wr_a_valid, wr_b_valid  in  1  write request pending (A = ALU, B = load).
- wr_a_ready, wr_b_ready  out  1  write accepted this cycle.
- wr_a_addr, wr_b_addr  in  RWIDTH  write address.
- wr_a_data, wr_b_data  in  DWIDTH  write data.
- rf_ra1, rf_ra2, rf_wa  out  RWIDTH  to register file.
- rf_wd  out  DWIDTH  to register file.
- rf_we  out  1  to register file.
- rf_rd1, rf_rd2  in  DWIDTH  from register file.
- init_busy  out  1  initialization sweep in progress.

## Operation
- States: INIT and RUN. `rst` forces INIT with the following register values:
  - sweep counter = 1
  - rr_ptr = A
  - starve_cnt = 0
  - rsp_pending = 0
- INIT:
  - Drives rf_we=1, rf_wa=counter, rf_wd=0 each cycle and increments the counter.
  - Leaves INIT for RUN after writing address 2**RWIDTH-1; the counter wraps to 0 and is not used again.
  - Address 0 is never swept, because the register file hardwires writes to it off.
  - All *_ready = 0 and init_busy = 1 throughout INIT.
- RUN: exactly one grant per cycle, decided combinationally from the current valids and state:
  1. Read, if rd_req_valid and starve_cnt == STARVE_LIMIT.
  2. Writer selected by rr_ptr, if valid.
  3. Other writer, if valid.
  4. Read, if rd_req_valid.
- Grant outputs: ready=1 only for the granted requester.
  - Write grant: rf_we=1, rf_wa/rf_wd taken from the grantee.
  - Read grant: rf_we=0, rf_ra1/rf_ra2 = rd_ra1/rd_ra2.
  - No grant: rf_we=0, rf_ra* hold the last read addresses.
- rr_ptr update: after any write grant, rr_ptr points to the writer that was not granted.
- starve_cnt update:
  - Increments (saturating at STARVE_LIMIT) in each RUN cycle with rd_req_valid=1 and no read grant.
  - Clears on read grant or when rd_req_valid=0.
- A write to address 0 is accepted and forwarded normally; it has no architectural effect.
- Requesters hold valid and payload stable until ready; valid must not depend on ready. ready is combinational from valid.
- Read data reflects every write granted in an earlier cycle. A write and a read are never granted in the same cycle.
- rd_rsp_d1/d2 are combinational pass-throughs of rf_rd1/rf_rd2. They are meaningful only while rd_rsp_valid=1.

## Timing
- Read grant in cycle T: regfile samples on the edge ending T; rd_rsp_valid=1 during T+1 only. Latency 1; throughput up to one read per cycle.
- The response has no backpressure and the consumer must take it in T+1. rsp_pending records the grant.
- Write grant in cycle T: register updated at the edge ending T.
- INIT lasts 2**RWIDTH-1 cycles (63 at default) after the first cycle with rst=0. init_busy falls and the first grant can occur in cycle 63.
- While rst=1: rf_we=0, all ready=0, rd_rsp_valid=0, init_busy=1, regardless of current state.
- Reset mid-operation: any in-flight response is dropped (rd_rsp_valid=0 in the cycle after reset). The full sweep restarts from 1.
- Worst-case read wait under continuous write traffic: STARVE_LIMIT+1 cycles.

## Test plan
- **Init sweep:** pulse rst, hold all valids=1.
  - Expect rf_we=1 with rf_wa counting 1..63 and rf_wd=0, and no ready during the sweep.
  - Expect init_busy to fall in cycle 63.
- **Write-then-read:** A writes 0xDEADBEEF to r5 in cycle T; read of r5/r0 requested in T+1.
  - Expect rd_rsp_valid in T+2 with d1=0xDEADBEEF, d2=0.
- **Round-robin:** A and B both valid continuously, no read.
  - Grants alternate A,B,A,B starting from A after reset.
  - Each write is visible on later reads.
- **Starvation:** A and B continuously valid, read valid from cycle T.
  - Read granted in cycle T+4 (STARVE_LIMIT=4), response in T+5, then writes resume alternating.
- **Address 0:** B writes 0x12345678 to r0; then read r0.
  - Expect wr_b_ready=1, response d1=0.
- **Reset mid-read:** read granted in T, rst=1 in T+1.
  - Expect rd_rsp_valid=0 in T+1 and T+2, init_busy=1, and the sweep restarting at address 1.

Source files
------------

// File: rtl/regfile_port_sched.sv
// Access-slot arbiter for the single-ported 64x32 register file: one decode read
// requester, two writeback requesters (A = ALU, B = load), plus a post-reset zeroing sweep.
module regfile_port_sched #(
   parameter int RWIDTH       = 6,
   parameter int DWIDTH       = 32,
   parameter int STARVE_LIMIT = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rd_req_valid,
   output logic              rd_req_ready,
   input  logic [RWIDTH-1:0] rd_ra1,
   input  logic [RWIDTH-1:0] rd_ra2,
   output logic              rd_rsp_valid,
   output logic [DWIDTH-1:0] rd_rsp_d1,
   output logic [DWIDTH-1:0] rd_rsp_d2,
   input  logic              wr_a_valid,
   input  logic              wr_b_valid,
   output logic              wr_a_ready,
   output logic              wr_b_ready,
   input  logic [RWIDTH-1:0] wr_a_addr,
   input  logic [RWIDTH-1:0] wr_b_addr,
   input  logic [DWIDTH-1:0] wr_a_data,
   input  logic [DWIDTH-1:0] wr_b_data,
   output logic [RWIDTH-1:0] rf_ra1,
   output logic [RWIDTH-1:0] rf_ra2,
   output logic [RWIDTH-1:0] rf_wa,
   output logic [DWIDTH-1:0] rf_wd,
   output logic              rf_we,
   input  logic [DWIDTH-1:0] rf_rd1,
   input  logic [DWIDTH-1:0] rf_rd2,
   output logic              init_busy
);

   typedef enum logic {ST_INIT, ST_RUN} state_t;

   localparam logic [RWIDTH-1:0] LAST_ADDR  = '1;
   localparam logic [3:0]        STARVE_MAX = 4'(STARVE_LIMIT);

   state_t            r_state;
   state_t            w_nextState;
   logic [RWIDTH-1:0] r_cnt;
   logic              r_rrPtr;
   logic [3:0]        r_starveCnt;
   logic              r_rspPending;
   logic [RWIDTH-1:0] r_lastRa1;
   logic [RWIDTH-1:0] r_lastRa2;
   logic              w_grantA;
   logic              w_grantB;
   logic              w_grantRd;
   logic              w_run;

   assign w_run = !rst && (r_state == ST_RUN);

   // r_rrPtr: 0 favours A, 1 favours B; a starved read outranks both writers
   always_comb begin
      w_grantA  = 1'b0;
      w_grantB  = 1'b0;
      w_grantRd = 1'b0;
      if (w_run) begin
         if (rd_req_valid && (r_starveCnt == STARVE_MAX)) w_grantRd = 1'b1;
         else if (!r_rrPtr && wr_a_valid)                w_grantA  = 1'b1;
         else if (r_rrPtr && wr_b_valid)                 w_grantB  = 1'b1;
         else if (wr_a_valid)                            w_grantA  = 1'b1;
         else if (wr_b_valid)                            w_grantB  = 1'b1;
         else if (rd_req_valid)                          w_grantRd = 1'b1;
      end
   end

   always_comb begin
      w_nextState = r_state;
      rf_we       = 1'b0;
      rf_wa       = r_cnt;
      rf_wd       = '0;
      rf_ra1      = r_lastRa1;
      rf_ra2      = r_lastRa2;
      if (!rst && (r_state == ST_INIT)) begin
         rf_we = 1'b1;
         if (r_cnt == LAST_ADDR) w_nextState = ST_RUN;
      end else if (w_grantA) begin
         rf_we = 1'b1;
         rf_wa = wr_a_addr;
         rf_wd = wr_a_data;
      end else if (w_grantB) begin
         rf_we = 1'b1;
         rf_wa = wr_b_addr;
         rf_wd = wr_b_data;
      end else if (w_grantRd) begin
         rf_ra1 = rd_ra1;
         rf_ra2 = rd_ra2;
      end
   end

   assign wr_a_ready   = w_grantA;
   assign wr_b_ready   = w_grantB;
   assign rd_req_ready = w_grantRd;
   assign rd_rsp_valid = r_rspPending && !rst;
   assign rd_rsp_d1    = rf_rd1;
   assign rd_rsp_d2    = rf_rd2;
   assign init_busy    = rst || (r_state == ST_INIT);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= ST_INIT;
         r_cnt        <= RWIDTH'(1);
         r_rrPtr      <= 1'b0;
         r_starveCnt  <= '0;
         r_rspPending <= 1'b0;
         r_lastRa1    <= '0;
         r_lastRa2    <= '0;
      end else begin
         r_state      <= w_nextState;
         r_rspPending <= w_grantRd;
         if (r_state == ST_INIT) r_cnt <= r_cnt + RWIDTH'(1);
         if (w_grantA)      r_rrPtr <= 1'b1;
         else if (w_grantB) r_rrPtr <= 1'b0;
         if (w_run && rd_req_valid && !w_grantRd) begin
            if (r_starveCnt != STARVE_MAX) r_starveCnt <= r_starveCnt + 4'd1;
         end else begin
            r_starveCnt <= '0;
         end
         if (w_grantRd) begin
            r_lastRa1 <= rd_ra1;
            r_lastRa2 <= rd_ra2;
         end
      end
   end

endmodule

// File: tb/tb_regfile_port_sched.sv
// Directed-vector bench for regfile_port_sched; a behavioural register file stub
// sits behind the DUT and a queue-based monitor checks every read response.
module tb_regfile_port_sched;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        rd_req_valid = 1'b0;
   logic        rd_req_ready;
   logic [5:0]  rd_ra1 = '0;
   logic [5:0]  rd_ra2 = '0;
   logic        rd_rsp_valid;
   logic [31:0] rd_rsp_d1;
   logic [31:0] rd_rsp_d2;
   logic        wr_a_valid = 1'b0;
   logic        wr_b_valid = 1'b0;
   logic        wr_a_ready;
   logic        wr_b_ready;
   logic [5:0]  wr_a_addr = '0;
   logic [5:0]  wr_b_addr = '0;
   logic [31:0] wr_a_data = '0;
   logic [31:0] wr_b_data = '0;
   logic [5:0]  rf_ra1;
   logic [5:0]  rf_ra2;
   logic [5:0]  rf_wa;
   logic [31:0] rf_wd;
   logic        rf_we;
   logic [31:0] rf_rd1;
   logic [31:0] rf_rd2;
   logic        init_busy;

   typedef struct {
      logic [31:0] d1;
      logic [31:0] d2;
      int          cyc;
   } rsp_t;

   rsp_t expQ[$];
   rsp_t monE;
   int   vectors     = 0;
   int   miscompares = 0;
   int   cycleCnt    = 0;

   logic [31:0] mem [64];
   logic [63:0] written = '0;

   regfile_port_sched #(.RWIDTH(6), .DWIDTH(32), .STARVE_LIMIT(4)) dut (
      .clk(clk), .rst(rst),
      .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready),
      .rd_ra1(rd_ra1), .rd_ra2(rd_ra2),
      .rd_rsp_valid(rd_rsp_valid), .rd_rsp_d1(rd_rsp_d1), .rd_rsp_d2(rd_rsp_d2),
      .wr_a_valid(wr_a_valid), .wr_b_valid(wr_b_valid),
      .wr_a_ready(wr_a_ready), .wr_b_ready(wr_b_ready),
      .wr_a_addr(wr_a_addr), .wr_b_addr(wr_b_addr),
      .wr_a_data(wr_a_data), .wr_b_data(wr_b_data),
      .rf_ra1(rf_ra1), .rf_ra2(rf_ra2), .rf_wa(rf_wa), .rf_wd(rf_wd), .rf_we(rf_we),
      .rf_rd1(rf_rd1), .rf_rd2(rf_rd2), .init_busy(init_busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cycleCnt <= cycleCnt + 1;

   // Never-written registers return a recognisable junk pattern so the zeroing sweep is observable
   function automatic logic [31:0] rdWord(input logic [5:0] a);
      if (a == 6'd0)       return 32'd0;
      else if (!written[a]) return {16'hBAD0, 10'd0, a};
      else                 return mem[a];
   endfunction

   always @(posedge clk) begin
      if (rf_we) begin
         if (rf_wa != 6'd0) begin
            mem[rf_wa]     <= rf_wd;
            written[rf_wa] <= 1'b1;
         end
      end else begin
         rf_rd1 <= rdWord(rf_ra1);
         rf_rd2 <= rdWord(rf_ra2);
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cycleCnt);
      end
   endtask

   always @(negedge clk) begin
      if (rd_rsp_valid) begin
         if (expQ.size() == 0) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL rsp_unexpected: got rd_rsp_valid=1 expected 0 (cycle %0d)", cycleCnt);
         end else begin
            monE = expQ.pop_front();
            checkOutput("rsp_cycle", 32'(cycleCnt), 32'(monE.cyc));
            checkOutput("rsp_d1", rd_rsp_d1, monE.d1);
            checkOutput("rsp_d2", rd_rsp_d2, monE.d2);
         end
      end else if (expQ.size() > 0 && expQ[0].cyc <= cycleCnt) begin
         monE = expQ.pop_front();
         vectors++;
         miscompares++;
         $display("[TB] FAIL rsp_missing: got rd_rsp_valid=0 expected 1 (cycle %0d)", cycleCnt);
      end
   end

   // expGrant is {read, B, A}; a read grant with expRsp set queues the response due next cycle
   task automatic applyStimulus(input string tag,
                                input logic aV, input logic [5:0] aAd, input logic [31:0] aD,
                                input logic bV, input logic [5:0] bAd, input logic [31:0] bD,
                                input logic rV, input logic [5:0] r1, input logic [5:0] r2,
                                input logic [2:0] expGrant, input logic expRsp,
                                input logic [31:0] e1, input logic [31:0] e2);
      rsp_t e;
      wr_a_valid = aV; wr_a_addr = aAd; wr_a_data = aD;
      wr_b_valid = bV; wr_b_addr = bAd; wr_b_data = bD;
      rd_req_valid = rV; rd_ra1 = r1; rd_ra2 = r2;
      @(negedge clk);
      checkOutput({tag, "_grant"}, 32'({rd_req_ready, wr_b_ready, wr_a_ready}), 32'(expGrant));
      case (expGrant)
         3'b001: begin
            checkOutput({tag, "_we"}, 32'(rf_we), 32'd1);
            checkOutput({tag, "_wa"}, 32'(rf_wa), 32'(aAd));
            checkOutput({tag, "_wd"}, rf_wd, aD);
         end
         3'b010: begin
            checkOutput({tag, "_we"}, 32'(rf_we), 32'd1);
            checkOutput({tag, "_wa"}, 32'(rf_wa), 32'(bAd));
            checkOutput({tag, "_wd"}, rf_wd, bD);
         end
         3'b100: begin
            checkOutput({tag, "_we"}, 32'(rf_we), 32'd0);
            checkOutput({tag, "_ra1"}, 32'(rf_ra1), 32'(r1));
            checkOutput({tag, "_ra2"}, 32'(rf_ra2), 32'(r2));
            if (expRsp) begin
               e.d1 = e1; e.d2 = e2; e.cyc = cycleCnt + 1;
               expQ.push_back(e);
            end
         end
         default: checkOutput({tag, "_we"}, 32'(rf_we), 32'd0);
      endcase
      @(posedge clk); #1;
   endtask

   task automatic checkSweep(input int first);
      for (int i = first; i < 64; i++) begin
         @(negedge clk);
         checkOutput("sweep_we", 32'(rf_we), 32'd1);
         checkOutput("sweep_wa", 32'(rf_wa), 32'(i));
         checkOutput("sweep_wd", rf_wd, 32'd0);
         checkOutput("sweep_ready", 32'({rd_req_ready, wr_b_ready, wr_a_ready}), 32'd0);
         checkOutput("sweep_busy", 32'(init_busy), 32'd1);
         @(posedge clk); #1;
      end
      checkOutput("init_done", 32'(init_busy), 32'd0);
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: got no finish expected finish by 100us");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      // All requesters pending through reset and the sweep; nothing may be granted
      wr_a_valid = 1'b1; wr_a_addr = 6'd7; wr_a_data = 32'h11111111;
      wr_b_valid = 1'b1; wr_b_addr = 6'd8; wr_b_data = 32'h22222222;
      rd_req_valid = 1'b1; rd_ra1 = 6'd7; rd_ra2 = 6'd8;
      repeat (2) begin
         @(negedge clk);
         checkOutput("rst_we", 32'(rf_we), 32'd0);
         checkOutput("rst_ready", 32'({rd_req_ready, wr_b_ready, wr_a_ready}), 32'd0);
         checkOutput("rst_busy", 32'(init_busy), 32'd1);
         checkOutput("rst_rsp", 32'(rd_rsp_valid), 32'd0);
         @(posedge clk); #1;
      end
      rst = 1'b0;
      checkSweep(1);

      applyStimulus("first_a", 1, 7, 32'h11111111, 1, 8, 32'h22222222, 1, 7, 8, 3'b001, 0, 0, 0);
      applyStimulus("first_b", 0, 0, 0, 1, 8, 32'h22222222, 1, 7, 8, 3'b010, 0, 0, 0);
      applyStimulus("first_rd", 0, 0, 0, 0, 0, 0, 1, 7, 8, 3'b100, 1, 32'h11111111, 32'h22222222);

      applyStimulus("wtr_wr", 1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 3'b001, 0, 0, 0);
      applyStimulus("wtr_rd", 0, 0, 0, 0, 0, 0, 1, 5, 0, 3'b100, 1, 32'hDEADBEEF, 32'd0);
      applyStimulus("swept_rd", 0, 0, 0, 0, 0, 0, 1, 9, 10, 3'b100, 1, 32'd0, 32'd0);

      applyStimulus("rr1", 1, 10, 32'hA0A0A0A0, 1, 11, 32'hB0B0B0B0, 0, 0, 0, 3'b010, 0, 0, 0);
      applyStimulus("rr2", 1, 10, 32'hA0A0A0A0, 1, 12, 32'hB1B1B1B1, 0, 0, 0, 3'b001, 0, 0, 0);
      applyStimulus("rr3", 1, 13, 32'hA1A1A1A1, 1, 12, 32'hB1B1B1B1, 0, 0, 0, 3'b010, 0, 0, 0);
      applyStimulus("rr4", 1, 13, 32'hA1A1A1A1, 1, 14, 32'hB2B2B2B2, 0, 0, 0, 3'b001, 0, 0, 0);
      applyStimulus("rr5", 0, 0, 0, 1, 14, 32'hB2B2B2B2, 0, 0, 0, 3'b010, 0, 0, 0);
      applyStimulus("rr_rd1", 0, 0, 0, 0, 0, 0, 1, 10, 11, 3'b100, 1, 32'hA0A0A0A0, 32'hB0B0B0B0);
      applyStimulus("rr_rd2", 0, 0, 0, 0, 0, 0, 1, 12, 13, 3'b100, 1, 32'hB1B1B1B1, 32'hA1A1A1A1);
      applyStimulus("rr_rd3", 0, 0, 0, 0, 0, 0, 1, 14, 0, 3'b100, 1, 32'hB2B2B2B2, 32'd0);

      applyStimulus("stv0", 1, 20, 32'hC0C0C0C0, 1, 21, 32'hD0D0D0D0, 1, 20, 23, 3'b001, 0, 0, 0);
      applyStimulus("stv1", 1, 22, 32'hC1C1C1C1, 1, 21, 32'hD0D0D0D0, 1, 20, 23, 3'b010, 0, 0, 0);
      applyStimulus("stv2", 1, 22, 32'hC1C1C1C1, 1, 23, 32'hD1D1D1D1, 1, 20, 23, 3'b001, 0, 0, 0);
      applyStimulus("stv3", 1, 24, 32'hC2C2C2C2, 1, 23, 32'hD1D1D1D1, 1, 20, 23, 3'b010, 0, 0, 0);
      applyStimulus("stv4", 1, 24, 32'hC2C2C2C2, 1, 25, 32'hD2D2D2D2, 1, 20, 23, 3'b100, 1,
                    32'hC0C0C0C0, 32'hD1D1D1D1);
      applyStimulus("stv5", 1, 24, 32'hC2C2C2C2, 1, 25, 32'hD2D2D2D2, 0, 0, 0, 3'b001, 0, 0, 0);
      applyStimulus("stv6", 0, 0, 0, 1, 25, 32'hD2D2D2D2, 0, 0, 0, 3'b010, 0, 0, 0);
      applyStimulus("stv_rd", 0, 0, 0, 0, 0, 0, 1, 24, 25, 3'b100, 1, 32'hC2C2C2C2, 32'hD2D2D2D2);

      applyStimulus("r0_wr", 0, 0, 0, 1, 0, 32'h12345678, 0, 0, 0, 3'b010, 0, 0, 0);
      applyStimulus("r0_rd", 0, 0, 0, 0, 0, 0, 1, 0, 0, 3'b100, 1, 32'd0, 32'd0);

      // Read granted, then reset lands in the response cycle: the response must vanish
      applyStimulus("mid_rd", 0, 0, 0, 0, 0, 0, 1, 5, 0, 3'b100, 0, 0, 0);
      rst = 1'b1; rd_req_valid = 1'b0;
      @(negedge clk);
      checkOutput("midrst_rsp", 32'(rd_rsp_valid), 32'd0);
      checkOutput("midrst_busy", 32'(init_busy), 32'd1);
      checkOutput("midrst_we", 32'(rf_we), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      checkOutput("postrst_rsp", 32'(rd_rsp_valid), 32'd0);
      checkOutput("postrst_busy", 32'(init_busy), 32'd1);
      checkOutput("postrst_we", 32'(rf_we), 32'd1);
      checkOutput("postrst_wa", 32'(rf_wa), 32'd1);
      @(posedge clk); #1;
      checkSweep(2);
      applyStimulus("resweep_rd", 0, 0, 0, 0, 0, 0, 1, 5, 24, 3'b100, 1, 32'd0, 32'd0);
      applyStimulus("idle1", 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0);
      applyStimulus("idle2", 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0);
      checkOutput("rsp_queue_empty", 32'(expQ.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
